// File: rtl/execute_stage_md.sv
// Execute stage with operand forwarding, ALU, and a multi-cycle
// multiply/divide unit holding the architectural HI/LO registers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   validE            E slot holds a real instruction
//   regDstE, aluSrcE  destination select, ALU B source select
//   aluControlE       ALU function
//   mdOpE             multiply/divide/HI-LO move opcode
//   rd1D, rd2D        register-file operands
//   rsE, rtE, rdE     register specifiers
//   signImmE          extended immediate
//   aluOutMOut        forwarded value from M
//   resultW           forwarded value from W
//   forwardAE/BE      forwarding selects (0 reg, 1 W, 2 M, 3 zero)
//   rsEHazardUnit     rsE passthrough to the hazard unit
//   rtEHazardUnit     rtE passthrough to the hazard unit
//   writeRegE         destination register
//   writeDataE        forwarded B operand
//   aluOutE           ALU result, or HI/LO for MFHI/MFLO
//   mdBusyE           multiply/divide unit busy
//   stallMDE          stall request to the hazard unit
//   hiOut, loOut      current HI/LO
module execute_stage_md #(
    parameter int WIDTH   = 32,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validE,
    input  logic              regDstE,
    input  logic              aluSrcE,
    input  logic [3:0]        aluControlE,
    input  logic [3:0]        mdOpE,
    input  logic [WIDTH-1:0]  rd1D,
    input  logic [WIDTH-1:0]  rd2D,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] rdE,
    input  logic [WIDTH-1:0]  signImmE,
    input  logic [WIDTH-1:0]  aluOutMOut,
    input  logic [WIDTH-1:0]  resultW,
    input  logic [1:0]        forwardAE,
    input  logic [1:0]        forwardBE,
    output logic [REG_AW-1:0] rsEHazardUnit,
    output logic [REG_AW-1:0] rtEHazardUnit,
    output logic [REG_AW-1:0] writeRegE,
    output logic [WIDTH-1:0]  writeDataE,
    output logic [WIDTH-1:0]  aluOutE,
    output logic              mdBusyE,
    output logic              stallMDE,
    output logic [WIDTH-1:0]  hiOut,
    output logic [WIDTH-1:0]  loOut
);

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             signed_op;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_res;
    logic             busy;
    logic             hilo_op;
    logic             accept;

    // Forwarding muxes
    always_comb begin
        case (forwardAE)
            2'd0:    src_a = rd1D;
            2'd1:    src_a = resultW;
            2'd2:    src_a = aluOutMOut;
            default: src_a = '0;
        endcase
        case (forwardBE)
            2'd0:    writeDataE = rd2D;
            2'd1:    writeDataE = resultW;
            2'd2:    writeDataE = aluOutMOut;
            default: writeDataE = '0;
        endcase
    end

    assign src_b = aluSrcE ? signImmE : writeDataE;

    always_comb begin
        alu_res = '0;
        case (aluControlE)
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_NOR:  alu_res = ~(src_a | src_b);
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                 $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        if (mdOpE == MD_MFHI)
            aluOutE = hi;
        else if (mdOpE == MD_MFLO)
            aluOutE = lo;
        else
            aluOutE = alu_res;
    end

    assign rsEHazardUnit = rsE;
    assign rtEHazardUnit = rtE;
    assign writeRegE     = regDstE ? rdE : rtE;

    assign busy     = (state != S_IDLE);
    assign mdBusyE  = busy;
    assign hilo_op  = validE && (mdOpE != 4'd0) && (mdOpE <= MD_MTLO);
    assign stallMDE = hilo_op && busy;
    assign accept   = hilo_op && !busy;
    assign hiOut    = hi;
    assign loOut    = lo;

    // Multiplier: operands extended to 2*WIDTH so one unsigned
    // multiply yields the correct low 2*WIDTH bits in both modes.
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] prod;

    assign mul_a = signed_op ? {{WIDTH{op_a[WIDTH-1]}}, op_a}
                             : {{WIDTH{1'b0}}, op_a};
    assign mul_b = signed_op ? {{WIDTH{op_b[WIDTH-1]}}, op_b}
                             : {{WIDTH{1'b0}}, op_b};
    assign prod  = mul_a * mul_b;

    // One restoring-division step: shift the next dividend bit into
    // the partial remainder and subtract the divisor when it fits.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             take;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign take     = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx   = take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx   = {quo_q[WIDTH-2:0], take};
    assign quot_fin = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    assign rem_fin  = neg_r ? (~rem_nx + 1'b1) : rem_nx;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = (mdOpE == MD_DIV) && src_a[WIDTH-1];
    assign b_neg = (mdOpE == MD_DIV) && src_b[WIDTH-1];
    assign a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag = b_neg ? (~src_b + 1'b1) : src_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            signed_op <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (mdOpE)
                            MD_MULT, MD_MULTU: begin
                                op_a      <= src_a;
                                op_b      <= src_b;
                                signed_op <= (mdOpE == MD_MULT);
                                cnt       <= CW'(MUL_LAT - 1);
                                state     <= S_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                op_a      <= src_a;
                                op_b      <= src_b;
                                signed_op <= (mdOpE == MD_DIV);
                                rem_q     <= '0;
                                quo_q     <= a_mag;
                                dvs_q     <= b_mag;
                                neg_q     <= a_neg ^ b_neg;
                                neg_r     <= a_neg;
                                cnt       <= CW'(WIDTH - 1);
                                state     <= S_DIV;
                            end
                            MD_MTHI: hi <= src_a;
                            MD_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        lo    <= prod[WIDTH-1:0];
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt == '0) begin
                        // Divide by zero leaves the raw dividend in HI
                        if (dvs_q == '0) begin
                            lo <= '1;
                            hi <= op_a;
                        end else begin
                            lo <= quot_fin;
                            hi <= rem_fin;
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed self-checking bench for execute_stage_md.
// Drives hand-computed vectors and compares every result.
module tb_execute_stage_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        validE;
    logic        regDstE;
    logic        aluSrcE;
    logic [3:0]  aluControlE;
    logic [3:0]  mdOpE;
    logic [31:0] rd1D;
    logic [31:0] rd2D;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  rdE;
    logic [31:0] signImmE;
    logic [31:0] aluOutMOut;
    logic [31:0] resultW;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic [4:0]  rsEHazardUnit;
    logic [4:0]  rtEHazardUnit;
    logic [4:0]  writeRegE;
    logic [31:0] writeDataE;
    logic [31:0] aluOutE;
    logic        mdBusyE;
    logic        stallMDE;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int n_tests = 0;
    int n_fail  = 0;

    execute_stage_md #(
        .WIDTH(32),
        .REG_AW(5),
        .MUL_LAT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .validE(validE),
        .regDstE(regDstE),
        .aluSrcE(aluSrcE),
        .aluControlE(aluControlE),
        .mdOpE(mdOpE),
        .rd1D(rd1D),
        .rd2D(rd2D),
        .rsE(rsE),
        .rtE(rtE),
        .rdE(rdE),
        .signImmE(signImmE),
        .aluOutMOut(aluOutMOut),
        .resultW(resultW),
        .forwardAE(forwardAE),
        .forwardBE(forwardBE),
        .rsEHazardUnit(rsEHazardUnit),
        .rtEHazardUnit(rtEHazardUnit),
        .writeRegE(writeRegE),
        .writeDataE(writeDataE),
        .aluOutE(aluOutE),
        .mdBusyE(mdBusyE),
        .stallMDE(stallMDE),
        .hiOut(hiOut),
        .loOut(loOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one md op, then count busy cycles until the unit drops busy
    task automatic run_md(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int n);
        @(negedge clk);
        rd1D      = a;
        rd2D      = b;
        forwardAE = 2'd0;
        forwardBE = 2'd0;
        aluSrcE   = 1'b0;
        validE    = 1'b1;
        mdOpE     = op;
        @(posedge clk);
        #1;
        validE = 1'b0;
        mdOpE  = 4'd0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mdBusyE) break;
            n++;
        end
    endtask

    int nb;
    int stalls;

    initial begin
        rst         = 1'b1;
        validE      = 1'b0;
        regDstE     = 1'b0;
        aluSrcE     = 1'b0;
        aluControlE = 4'b0010;
        mdOpE       = 4'd0;
        rd1D        = '0;
        rd2D        = '0;
        rsE         = 5'd3;
        rtE         = 5'd7;
        rdE         = 5'd12;
        signImmE    = '0;
        aluOutMOut  = '0;
        resultW     = '0;
        forwardAE   = 2'd0;
        forwardBE   = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(mdBusyE), 64'd0);
        check("rst_hi", 64'(hiOut), 64'd0);
        check("rst_lo", 64'(loOut), 64'd0);
        validE = 1'b1;
        mdOpE  = 4'd5;
        #1;
        check("rst_stall", 64'(stallMDE), 64'd0);
        check("rst_mfhi", 64'(aluOutE), 64'd0);
        validE = 1'b0;
        mdOpE  = 4'd0;

        // Multiply
        run_md(4'd1, 32'hFFFF_FFFD, 32'd5, nb);
        check("mult_busy", 64'(nb), 64'd4);
        check("mult_hi", 64'(hiOut), 64'hFFFF_FFFF);
        check("mult_lo", 64'(loOut), 64'hFFFF_FFF1);
        run_md(4'd2, 32'hFFFF_FFFD, 32'd5, nb);
        check("multu_busy", 64'(nb), 64'd4);
        check("multu_hi", 64'(hiOut), 64'h4);
        check("multu_lo", 64'(loOut), 64'hFFFF_FFF1);

        // Divide
        run_md(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_busy", 64'(nb), 64'd32);
        check("div_lo", 64'(loOut), 64'hFFFF_FFFD);
        check("div_hi", 64'(hiOut), 64'hFFFF_FFFF);
        run_md(4'd4, 32'd100, 32'd7, nb);
        check("divu_busy", 64'(nb), 64'd32);
        check("divu_lo", 64'(loOut), 64'd14);
        check("divu_hi", 64'(hiOut), 64'd2);
        mdOpE = 4'd6;
        #1;
        check("mflo", 64'(aluOutE), 64'd14);
        mdOpE = 4'd0;

        // Stall window: MFHI right behind a MULT
        @(negedge clk);
        rd1D   = 32'h0001_0000;
        rd2D   = 32'h0003_0000;
        validE = 1'b1;
        mdOpE  = 4'd1;
        @(posedge clk);
        #1;
        mdOpE  = 4'd5;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stallMDE) break;
            stalls++;
        end
        check("mfhi_stalls", 64'(stalls), 64'd4);
        check("mfhi_value", 64'(aluOutE), 64'd3);
        @(posedge clk);
        #1;
        validE = 1'b0;
        mdOpE  = 4'd0;

        // Divide by zero and overflow case
        run_md(4'd4, 32'd5, 32'd0, nb);
        check("div0_busy", 64'(nb), 64'd32);
        check("div0_lo", 64'(loOut), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hiOut), 64'd5);
        run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divmin_lo", 64'(loOut), 64'h8000_0000);
        check("divmin_hi", 64'(hiOut), 64'd0);

        // Forwarding and destination select
        @(negedge clk);
        rd1D        = 32'd1;
        resultW     = 32'd2;
        aluOutMOut  = 32'd3;
        aluSrcE     = 1'b1;
        signImmE    = 32'd0;
        aluControlE = 4'b0010;
        forwardAE   = 2'd0; #1 check("fwd_a0", 64'(aluOutE), 64'd1);
        forwardAE   = 2'd1; #1 check("fwd_a1", 64'(aluOutE), 64'd2);
        forwardAE   = 2'd2; #1 check("fwd_a2", 64'(aluOutE), 64'd3);
        forwardAE   = 2'd3; #1 check("fwd_a3", 64'(aluOutE), 64'd0);
        forwardBE   = 2'd2; #1 check("fwd_b2", 64'(writeDataE), 64'd3);
        regDstE     = 1'b1; #1 check("wreg_rd", 64'(writeRegE), 64'd12);
        regDstE     = 1'b0; #1 check("wreg_rt", 64'(writeRegE), 64'd7);
        check("rs_pass", 64'(rsEHazardUnit), 64'd3);
        rd1D        = 32'd10;
        rd2D        = 32'd3;
        forwardAE   = 2'd0;
        forwardBE   = 2'd0;
        aluSrcE     = 1'b0;
        aluControlE = 4'b0110;
        #1 check("alu_sub", 64'(aluOutE), 64'd7);
        aluControlE = 4'b0010;

        // Reset in the middle of a divide
        @(negedge clk);
        rd1D   = 32'd100;
        rd2D   = 32'd3;
        validE = 1'b1;
        mdOpE  = 4'd3;
        @(posedge clk);
        #1;
        validE = 1'b0;
        mdOpE  = 4'd0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(mdBusyE), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(mdBusyE), 64'd0);
        check("mid_rst_hi", 64'(hiOut), 64'd0);
        check("mid_rst_lo", 64'(loOut), 64'd0);
        rd1D   = 32'h1234;
        validE = 1'b1;
        mdOpE  = 4'd8;
        #1;
        check("mtlo_stall", 64'(stallMDE), 64'd0);
        @(posedge clk);
        #1;
        validE = 1'b0;
        mdOpE  = 4'd0;
        check("mtlo_lo", 64'(loOut), 64'h1234);
        check("mtlo_hi", 64'(hiOut), 64'd0);
        check("mtlo_busy", 64'(mdBusyE), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
